// File: rtl/ln_rcv_pkg.sv
// Shared widths, flag constants and FSM state encoding for the ln_rcv link receiver.
package ln_rcv_pkg;

  localparam int unsigned ADDRESS_SIZE = 8;
  localparam int unsigned DATA_SIZE    = 8;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/ln_rcv_fifo.sv
// Synchronous FIFO buffering accepted link payloads; extra pointer MSB separates full from empty.
module ln_rcv_fifo
  import ln_rcv_pkg::*;
#(
  parameter int unsigned DSZ   = DATA_SIZE,
  parameter int unsigned DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           push,
  input  logic [DSZ-1:0] din,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output logic [DSZ-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [DSZ-1:0] mem [DEPTH];
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ln_rcv.sv
// Receiving end of the 4-phase addr/dat/req/ack link: synchronises req, filters on address,
// checks the data sequence and buffers accepted payloads for a stallable local consumer.
module ln_rcv
  import ln_rcv_pkg::*;
#(
  parameter int unsigned        ASZ        = ADDRESS_SIZE,
  parameter int unsigned        DSZ        = DATA_SIZE,
  parameter logic [ASZ-1:0]     LOCAL_ADDR = '0,
  parameter int unsigned        DEPTH      = 4,
  parameter logic               CHK_SEQ    = ON
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [ASZ-1:0] i_addr,
  input  logic [DSZ-1:0] i_dat,
  input  logic           i_req,
  output logic           o_ack,
  output logic [DSZ-1:0] o_dat,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [DSZ-1:0] o_ck_dat,
  output logic           o_err,
  output logic [1:0]     o_err_code
);

  state_t     state;
  state_t     state_nxt;
  logic       req_m;
  logic       req_s;
  logic       capture;
  logic       addr_hit;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       seq_seen;
  logic       ack_nxt;
  logic [1:0] err_code;

  // Synchroniser resets high so a request still asserted across reset is seen as
  // in flight and S_SYNC waits for it to drop instead of capturing it twice.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_m <= 1'b1;
      req_s <= 1'b1;
    end else begin
      req_m <= i_req;
      req_s <= req_m;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      S_SYNC: if (!req_s) state_nxt = S_IDLE;
      S_IDLE: if (req_s && !full) begin
        capture   = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK:  if (!req_s) state_nxt = S_IDLE;
      default: state_nxt = S_SYNC;
    endcase
  end

  assign ack_nxt  = (state_nxt == S_ACK);
  assign addr_hit = (i_addr == LOCAL_ADDR);
  assign push     = capture && addr_hit;
  assign o_valid  = !empty;
  assign pop      = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ack    <= 1'b0;
      o_ck_dat <= '0;
      seq_seen <= 1'b0;
      err_code <= '0;
    end else begin
      o_ack <= ack_nxt;
      if (capture) begin
        if (addr_hit) begin
          o_ck_dat <= i_dat;
          seq_seen <= 1'b1;
          if (CHK_SEQ && seq_seen && (i_dat != o_ck_dat + DSZ'(1))) err_code[1] <= 1'b1;
        end else begin
          err_code[0] <= 1'b1;
        end
      end
    end
  end

  assign o_err_code = err_code;
  assign o_err      = |err_code;

  ln_rcv_fifo #(
    .DSZ   (DSZ),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .din     (i_dat),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (o_dat)
  );

endmodule

// File: tb/tb_ln_rcv.sv
// Directed self-checking bench for ln_rcv (ASZ=DSZ=8, LOCAL_ADDR=0, DEPTH=4, CHK_SEQ=1).
module tb_ln_rcv;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] dat = '0;
  logic       req = 1'b0;
  logic       ack;
  logic [7:0] odat;
  logic       valid;
  logic       ready = 1'b0;
  logic [7:0] ck_dat;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ln_rcv #(
    .ASZ        (8),
    .DSZ        (8),
    .LOCAL_ADDR (8'd0),
    .DEPTH      (4),
    .CHK_SEQ    (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_addr     (addr),
    .i_dat      (dat),
    .i_req      (req),
    .o_ack      (ack),
    .o_dat      (odat),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_ck_dat   (ck_dat),
    .o_err      (err),
    .o_err_code (err_code)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_ack(input int maxc, output int edges, output bit acked);
    edges = 0; acked = 1'b0;
    while (!acked && edges < maxc) begin
      @(posedge clk); #1;
      edges++;
      if (ack) acked = 1'b1;
    end
  endtask

  task automatic do_req(input logic [7:0] a, input logic [7:0] d, input int maxc,
                        output int edges, output bit acked);
    @(negedge clk);
    addr = a; dat = d; req = 1'b1;
    wait_ack(maxc, edges, acked);
  endtask

  task automatic drop_req(output bit released);
    int n;
    req = 1'b0; n = 0; released = 1'b0;
    while (!released && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (!ack) released = 1'b1;
    end
  endtask

  task automatic pop_one(output logic [7:0] v);
    @(negedge clk);
    v = odat;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; ready = 1'b0;
    #1;
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b want 0", ack); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_checks++; if (odat !== 8'd0) begin n_fail++; $display("FAIL reset_dat: got %0h want 0", odat); end
    n_checks++; if (ck_dat !== 8'd0) begin n_fail++; $display("FAIL reset_ck_dat: got %0h want 0", ck_dat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b want 00", err_code); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int e; bit ok; bit rel;
    do_req(8'd0, 8'd5, 10, e, ok);
    n_checks++; if (!ok || e != 3) begin n_fail++; $display("FAIL basic_latency: got acked=%0b edges=%0d want acked=1 edges=3", ok, e); end
    drop_req(rel);
    n_checks++; if (!rel) begin n_fail++; $display("FAIL basic_release: ack still high, want low"); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", valid); end
    n_checks++; if (odat !== 8'd5) begin n_fail++; $display("FAIL basic_dat: got %0h want 5", odat); end
    n_checks++; if (ck_dat !== 8'd5) begin n_fail++; $display("FAIL basic_ck_dat: got %0h want 5", ck_dat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %0b want 0", err); end
  endtask

  task automatic test_backpressure();
    int e; bit ok; bit rel; logic [7:0] v;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      do_req(8'd0, 8'(i), 10, e, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_ack%0d: got no ack want ack", i); end
      drop_req(rel);
    end
    do_req(8'd0, 8'd5, 8, e, ok);
    n_checks++; if (ok) begin n_fail++; $display("FAIL bp_withheld: got ack want none while full"); end
    pop_one(v);
    n_checks++; if (v !== 8'd1) begin n_fail++; $display("FAIL bp_pop1: got %0h want 1", v); end
    wait_ack(5, e, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_ack_after_pop: got no ack want ack"); end
    drop_req(rel);
    for (int i = 2; i <= 5; i++) begin
      pop_one(v);
      n_checks++; if (v !== 8'(i)) begin n_fail++; $display("FAIL bp_pop%0d: got %0h want %0h", i, v, 8'(i)); end
    end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid=%0b want 0", valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %0b want 0", err); end
  endtask

  task automatic test_addr_mismatch();
    int e; bit ok; bit rel;
    apply_reset();
    do_req(8'd1, 8'd3, 10, e, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL am_ack: got no ack want ack"); end
    drop_req(rel);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL am_no_push: got valid=%0b want 0", valid); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL am_err: got %0b want 1", err); end
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL am_code: got %b want 01", err_code); end
    do_req(8'd0, 8'd9, 10, e, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL am_good_ack: got no ack want ack"); end
    drop_req(rel);
    n_checks++; if (valid !== 1'b1 || odat !== 8'd9) begin n_fail++; $display("FAIL am_good_push: got valid=%0b dat=%0h want 1/9", valid, odat); end
    n_checks++; if (ck_dat !== 8'd9) begin n_fail++; $display("FAIL am_good_ck: got %0h want 9", ck_dat); end
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL am_code_kept: got %b want 01", err_code); end
  endtask

  task automatic test_sequence();
    int e; bit ok; bit rel; logic [7:0] v;
    apply_reset();
    do_req(8'd0, 8'd7, 10, e, ok); drop_req(rel);
    do_req(8'd0, 8'd9, 10, e, ok); drop_req(rel);
    n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL seq_break: got %b want 10", err_code); end
    pop_one(v);
    n_checks++; if (v !== 8'd7) begin n_fail++; $display("FAIL seq_pop7: got %0h want 7", v); end
    pop_one(v);
    n_checks++; if (v !== 8'd9) begin n_fail++; $display("FAIL seq_pop9: got %0h want 9", v); end
    apply_reset();
    do_req(8'd0, 8'd255, 10, e, ok); drop_req(rel);
    do_req(8'd0, 8'd0, 10, e, ok); drop_req(rel);
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL seq_wrap: got %b want 00", err_code); end
    n_checks++; if (ck_dat !== 8'd0) begin n_fail++; $display("FAIL seq_wrap_ck: got %0h want 0", ck_dat); end
  endtask

  task automatic test_reset_in_flight();
    int e; bit ok; bit rel; int acks;
    apply_reset();
    do_req(8'd0, 8'h11, 10, e, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rif_pre_ack: got no ack want ack"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rif_ack_async: got %0b want 0", ack); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rif_flush: got valid=%0b want 0", valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rif_no_dup: got %0d ack cycles want 0", acks); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rif_no_push: got valid=%0b want 0", valid); end
    drop_req(rel);
    repeat (4) @(negedge clk);
    do_req(8'd0, 8'h22, 10, e, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rif_new_ack: got no ack want ack"); end
    drop_req(rel);
    n_checks++; if (valid !== 1'b1 || odat !== 8'h22) begin n_fail++; $display("FAIL rif_new_dat: got valid=%0b dat=%0h want 1/22", valid, odat); end
  endtask

  task automatic test_back_to_back();
    int e; bit ok; bit rel; logic [7:0] v;
    logic [7:0] expq [$];
    int drops;
    apply_reset();
    do_req(8'd0, 8'h80, 10, e, ok); drop_req(rel);
    do_req(8'd0, 8'h81, 10, e, ok); drop_req(rel);
    expq.push_back(8'h80);
    expq.push_back(8'h81);
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      addr = 8'd0; dat = 8'(8'h82 + i); req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      v = odat;
      ready = 1'b1;
      n_checks++; if (v !== expq[0]) begin n_fail++; $display("FAIL b2b_order%0d: got %0h want %0h", i, v, expq[0]); end
      void'(expq.pop_front());
      expq.push_back(8'(8'h82 + i));
      @(posedge clk); #1;
      ready = 1'b0;
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack%0d: got %0b want 1", i, ack); end
      if (!valid) drops++;
      drop_req(rel);
      if (!valid) drops++;
    end
    n_checks++; if (drops != 0) begin n_fail++; $display("FAIL b2b_valid_held: got %0d empty samples want 0", drops); end
    for (int i = 0; i < 2; i++) begin
      pop_one(v);
      n_checks++; if (v !== expq[0]) begin n_fail++; $display("FAIL b2b_tail%0d: got %0h want %0h", i, v, expq[0]); end
      void'(expq.pop_front());
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %0b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_addr_mismatch();
    test_sequence();
    test_reset_in_flight();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
